// File: rtl/home_inventory_sample_sequencer.sv
// ============================================================================
// Module      : home_inventory_sample_sequencer
// Description : Periodic sensor-sweep sequencer. It walks an ADC req/ack
//               handshake across the enabled channels and emits snapshots
//               with a never-zero timestamp.
//               The optional ack timeout is enabled by HOME_INVENTORY_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module home_inventory_sample_sequencer #(
    parameter int NCH     = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [31:0]       period,
    input  logic [NCH-1:0]    chan_mask,
    input  logic              err_clr,
    output logic              adc_req,
    output logic [2:0]        adc_ch,
    input  logic              adc_ack,
    input  logic [31:0]       adc_data,
    output logic              sample_valid,
    output logic [31:0]       ts_now,
    output logic [NCH*32-1:0] sample_flat,
    output logic              busy,
    output logic [15:0]       overrun_cnt,
    output logic              timeout_err
);

    localparam int CHW = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [31:0]         r_cnt;
    logic [31:0]         r_seq;
    logic [31:0]         r_ts_pend;
    logic [NCH-1:0]      r_mask;
    logic [CHW-1:0]      r_ch;
    logic [NCH*32-1:0]   r_shadow;
    logic [NCH*32-1:0]   w_shadow_nxt;
    logic                w_tick;
    logic                w_timeout;
    logic                w_xfer;
    logic                w_adv;
    logic [CHW:0]        w_first;
    logic [CHW:0]        w_next;
    logic [31:0]         w_seq_inc;

    // Lowest set mask bit at or above lo; MSB of the result flags a hit.
    function automatic logic [CHW:0] first_at_or_above(input logic [NCH-1:0] m, input int lo);
        logic [CHW:0] res;
        res = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (i >= lo)) res = {1'b1, CHW'(i)};
        end
        return res;
    endfunction

    assign w_tick    = enable && (r_cnt == 32'd0);
    assign w_xfer    = (r_state == S_REQ) && adc_ack && !w_timeout;
    assign w_adv     = (r_state == S_REQ) && (adc_ack || w_timeout);
    assign w_first   = first_at_or_above(chan_mask, 0);
    assign w_next    = first_at_or_above(r_mask, int'(r_ch) + 1);
    assign w_seq_inc = (r_seq == 32'hFFFF_FFFF) ? r_seq : r_seq + 32'd1;

    assign adc_req      = (r_state == S_REQ);
    assign adc_ch       = r_ch;
    assign busy         = (r_state != S_IDLE);
    assign sample_valid = (r_state == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_tick) w_state_nxt = w_first[CHW] ? S_REQ : S_DONE;
            S_REQ:   if (w_adv && !w_next[CHW]) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A timed-out slot is written zero, so the last-channel merge covers both cases.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_adv) w_shadow_nxt[32*int'(r_ch) +: 32] = w_xfer ? adc_data : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!enable) begin
            r_cnt <= '0;
        end else if (r_cnt == 32'd0) begin
            r_cnt <= (period == 32'd0) ? 32'd0 : period - 32'd1;
        end else begin
            r_cnt <= r_cnt - 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_seq       <= '0;
            r_ts_pend   <= '0;
            r_mask      <= '0;
            r_ch        <= '0;
            r_shadow    <= '0;
            overrun_cnt <= '0;
            ts_now      <= '0;
            sample_flat <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_tick && (r_state == S_IDLE)) begin
                r_mask    <= chan_mask;
                r_shadow  <= '0;
                r_seq     <= w_seq_inc;
                r_ts_pend <= w_seq_inc;
                if (w_first[CHW]) r_ch <= w_first[CHW-1:0];
            end else if (w_tick && (overrun_cnt != 16'hFFFF)) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end

            if (w_adv) begin
                r_shadow <= w_shadow_nxt;
                if (w_next[CHW]) r_ch <= w_next[CHW-1:0];
            end

            // Publish on entry to DONE; an empty mask skips REQ entirely.
            if ((r_state == S_IDLE) && (w_state_nxt == S_DONE)) begin
                sample_flat <= '0;
                ts_now      <= w_seq_inc;
            end else if ((r_state == S_REQ) && (w_state_nxt == S_DONE)) begin
                sample_flat <= w_shadow_nxt;
                ts_now      <= r_ts_pend;
            end
        end
    end

`ifdef HOME_INVENTORY_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_wait;
    logic          r_err;

    assign w_timeout   = (r_state == S_REQ) && (r_wait == TW'(TIMEOUT));
    assign timeout_err = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            if ((r_state != S_REQ) || w_adv) r_wait <= '0;
            else                             r_wait <= r_wait + 1'b1;

            if (w_timeout)    r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end
`else
    localparam int c_unused_timeout = TIMEOUT;
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign w_timeout        = 1'b0;
    assign timeout_err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_home_inventory_sample_sequencer.sv
// ============================================================================
// Module      : tb_home_inventory_sample_sequencer
// Description : Directed self-checking bench for the sample sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_home_inventory_sample_sequencer;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic [31:0]  period = 32'd10;
    logic [7:0]   chan_mask = 8'hFF;
    logic         err_clr = 1'b0;
    logic         adc_req;
    logic [2:0]   adc_ch;
    logic         adc_ack = 1'b1;
    logic [31:0]  adc_data = 32'h0;
    logic         sample_valid;
    logic [31:0]  ts_now;
    logic [255:0] sample_flat;
    logic         busy;
    logic [15:0]  overrun_cnt;
    logic         timeout_err;

    int total = 0;
    int bad   = 0;
    int ack_mode = 0;   // 0: zero-wait, 1: ch2 acks on 4th cycle, 2: ch3 never acks
    int hold = 0;
    int req2 = 0;
    int nlog = 0;
    logic [2:0] xlog [16];

    always #5 clk = ~clk;

    home_inventory_sample_sequencer #(.NCH(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period),
        .chan_mask(chan_mask), .err_clr(err_clr),
        .adc_req(adc_req), .adc_ch(adc_ch), .adc_ack(adc_ack), .adc_data(adc_data),
        .sample_valid(sample_valid), .ts_now(ts_now), .sample_flat(sample_flat),
        .busy(busy), .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
    );

    // ADC responder and transfer logger
    initial begin
        forever begin
            @(negedge clk);
            if (adc_req && adc_ch == 3'd2 && ack_mode == 1) begin
                adc_ack  = (hold == 3);
                adc_data = (hold == 3) ? 32'h102 : 32'hDEAD_BEEF;
                hold++;
            end else if (adc_req && adc_ch == 3'd3 && ack_mode == 2) begin
                adc_ack  = 1'b0;
                adc_data = 32'h0000_0BAD;
            end else begin
                hold     = 0;
                adc_ack  = 1'b1;
                adc_data = 32'h100 + 32'(adc_ch);
            end
            if (adc_req && adc_ch == 3'd2) req2++;
            if (adc_req && adc_ack && nlog < 16) begin
                xlog[nlog] = adc_ch;
                nlog++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] slot(input int i);
        return sample_flat[32*i +: 32];
    endfunction

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < maxc);
        if (!sample_valid) begin
            total++;
            bad++;
            $display("FAIL wait_valid: got no sample_valid want pulse within %0d cycles", maxc);
        end
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(sample_valid), 0);
        chk("rst_req",   32'(adc_req), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_ts",    ts_now, 0);
        chk("rst_flat",  32'(|sample_flat), 0);
        chk("rst_ch",    32'(adc_ch), 0);
        chk("rst_ovr",   32'(overrun_cnt), 0);
        chk("rst_terr",  32'(timeout_err), 0);
        rst = 1'b0;
        @(negedge clk);

        // period 10, full mask, zero-wait ack
        enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_valid(30, n);
            chk("p10_gap", n, (k == 1) ? 9 : 10);
            chk("p10_ts", ts_now, k);
            for (int i = 0; i < 8; i++) chk("p10_slot", slot(i), 32'h100 + i);
            chk("p10_ovr", 32'(overrun_cnt), 0);
        end
        enable = 1'b0;
        @(negedge clk);
        chk("p10_stable_ts", ts_now, 3);
        repeat (3) @(negedge clk);

        // period 5: one dropped tick per scan
        period = 32'd5;
        enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_valid(30, n);
            chk("p5_gap", n, (k == 1) ? 9 : 10);
            chk("p5_ovr", 32'(overrun_cnt), k);
            chk("p5_ts", ts_now, 3 + k);
            chk("p5_slot0", slot(0), 32'h100);
            chk("p5_slot7", slot(7), 32'h107);
        end
        enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("p5_idle", 32'(busy), 0);

        // sparse mask; mask change after acceptance must not matter
        period = 32'd10;
        chan_mask = 8'b1000_0101;
        nlog = 0;
        pulse_enable();
        chan_mask = 8'h01;
        wait_valid(20, n);
        chk("m85_lat", n, 3);
        chk("m85_nxfer", nlog, 3);
        chk("m85_ord0", 32'(xlog[0]), 0);
        chk("m85_ord1", 32'(xlog[1]), 2);
        chk("m85_ord2", 32'(xlog[2]), 7);
        chk("m85_slot0", slot(0), 32'h100);
        chk("m85_slot2", slot(2), 32'h102);
        chk("m85_slot7", slot(7), 32'h107);
        chk("m85_masked", slot(1) | slot(3) | slot(4) | slot(5) | slot(6), 0);
        chk("m85_ts", ts_now, 7);
        repeat (2) @(negedge clk);

        // delayed ack on channel 2
        ack_mode = 1;
        chan_mask = 8'h0C;
        req2 = 0;
        pulse_enable();
        wait_valid(20, n);
        chk("dly_lat", n, 5);
        chk("dly_req_cycles", req2, 4);
        chk("dly_slot2", slot(2), 32'h102);
        chk("dly_slot3", slot(3), 32'h103);
        chk("dly_ts", ts_now, 8);
        ack_mode = 0;
        repeat (2) @(negedge clk);

        // reset in the middle of a scan
        chan_mask = 8'hFF;
        pulse_enable();
        repeat (2) @(negedge clk);
        chk("mid_req_before", 32'(adc_req), 1);
        rst = 1'b1;
        #1;
        chk("mid_req",   32'(adc_req), 0);
        chk("mid_busy",  32'(busy), 0);
        chk("mid_valid", 32'(sample_valid), 0);
        chk("mid_ts",    ts_now, 0);
        chk("mid_flat",  32'(|sample_flat), 0);
        chk("mid_ovr",   32'(overrun_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_enable();
        wait_valid(20, n);
        chk("post_rst_lat", n, 8);
        chk("post_rst_ts", ts_now, 1);
        repeat (2) @(negedge clk);

`ifdef HOME_INVENTORY_SEQ_TIMEOUT_EN
        // channel 3 never acks
        ack_mode = 2;
        chan_mask = 8'h18;
        pulse_enable();
        wait_valid(30, n);
        chk("to_lat", n, 6);
        chk("to_slot3", slot(3), 0);
        chk("to_slot4", slot(4), 32'h104);
        chk("to_err", 32'(timeout_err), 1);
        chk("to_ts", ts_now, 2);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to_clr", 32'(timeout_err), 0);
        @(negedge clk);
        // err_clr coinciding with the timeout cycle
        pulse_enable();
        repeat (TO) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to_set_wins", 32'(timeout_err), 1);
        wait_valid(20, n);
        ack_mode = 0;
`else
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("terr_const", 32'(timeout_err), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/home_inventory_sample_sequencer.md
# home_inventory_sample_sequencer

Sequences periodic acquisition of all eight sensor channels and feeds complete snapshots to the event detector. It generates a programmable sample tick and walks an ADC request/acknowledge handshake across the enabled channels. It then presents the snapshot with a single-cycle `sample_valid` and a monotonic, never-zero `ts_now`. It sits between the ADC capture front-end and `home_inventory_event_detector`.

## Interface
- `NCH`, 8, channel count; fixed at 8 in this revision.
- `TIMEOUT`, 255, maximum cycles `adc_req` may wait for `adc_ack` on one channel (timeout feature only).
- `clk`  in  1  single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  run sampling; 0 stops new ticks.
- `period`  in  32  tick period in clk cycles; 0 treated as 1.
- `chan_mask`  in  8  bit i=1 means channel i is acquired.
- `err_clr`  in  1  one-cycle pulse, clears `timeout_err`.
- `adc_req`  out  1  request a conversion on `adc_ch`.
- `adc_ch`  out  3  channel being requested; stable while `adc_req` is high and not acked.
- `adc_ack`  in  1  transfer occurs on a cycle with `adc_req && adc_ack`.
- `adc_data`  in  32  sample, valid on the transfer cycle.
- `sample_valid`  out  1  one-cycle pulse; snapshot and `ts_now` are new this cycle.
- `ts_now`  out  32  sequence timestamp of the current snapshot.
- `sample_flat`  out  256  snapshot; channel i is at bits [32*i+31:32*i].
- `busy`  out  1  scan in progress (state != IDLE).
- `overrun_cnt`  out  16  saturating count of dropped ticks.
- `timeout_err`  out  1  sticky ack-timeout flag.

## Operation
- Reset values: all outputs 0, including `sample_flat`, `ts_now` and `adc_ch`. The period counter is 0, the sequence counter is 0, and the state is IDLE.
- **Period counter:**
  - When `enable`=0, the counter is held at 0.
  - When `enable`=1 and the counter is 0, a tick is raised and the counter reloads with max(period,1)-1.
  - Otherwise the counter decrements.
  - The first tick occurs in the first cycle `enable` is sampled high.
- **Tick acceptance:**
  - A tick is accepted only in IDLE.
  - A tick in any other state is dropped and increments `overrun_cnt`, which saturates at 16'hFFFF.
  - On acceptance, the sequence counter increments, saturating at 32'hFFFF_FFFF, and its new value is latched as the pending timestamp. The first snapshot after reset therefore has ts 1, and the timestamp is never 0.
  - `chan_mask` is latched at acceptance; later changes do not affect the scan in flight.
- **States:**
  - IDLE: on an accepted tick, go to REQ on the lowest set latched-mask bit, or to DONE if the mask is 0.
  - REQ: `adc_req`=1 with `adc_ch`=current channel.
    - On transfer, write `adc_data` into the shadow slot.
    - Move to the next higher set bit, staying in REQ with `adc_req` held high and `adc_ch` updated the next cycle, or go to DONE when none remain.
  - DONE: one cycle with `adc_req`=0. Registered outputs update, then return to IDLE.
- Masked channels have their shadow slot written 32'h0 for that snapshot.
- `sample_flat` and `ts_now` change only in the cycle `sample_valid` is high. They are stable between pulses.
- Deasserting `enable` mid-scan does not abort: the scan completes and emits `sample_valid`. Only future ticks stop.
- Reset mid-scan: the scan is abandoned immediately, with outputs to reset values and no `sample_valid`.
- `err_clr` and a timeout set in the same cycle: set wins.

## Timing
- Tick accepted at cycle T: `adc_req` rises at T+1.
- With `adc_ack` tied 1 and n channels enabled, transfers occur at T+1..T+n. DONE is at T+n+1, where `sample_valid`, `sample_flat` and `ts_now` are all valid, and the block is back in IDLE at T+n+2.
- Mask 0: `sample_valid` at T+1.
- Minimum overrun-free period is n+2 with zero-wait ack; for 8 channels this is 10.
- `busy` is high from T+1 through DONE inclusive.

## Configuration
- `HOME_INVENTORY_SEQ_TIMEOUT_EN` defined:
  - A per-channel wait counter runs while in REQ without a transfer. It resets on each transfer or channel change.
  - When it reaches TIMEOUT, the slot is written 32'h0, `timeout_err` is set, and the scan advances exactly as if a transfer had occurred. An `adc_ack` on that same cycle is ignored.
- Undefined:
  - REQ waits indefinitely.
  - `timeout_err` is constant 0 and `err_clr` is ignored.

## Test plan
- Reset, `enable`=1, `period`=10, mask 8'hFF, `adc_ack`=1, `adc_data`=0x100+channel:
  - `sample_valid` at cycles 9, 19, 29, counting from enable at cycle 0.
  - `ts_now` = 1, 2, 3.
  - Slot i = 0x100+i.
  - `overrun_cnt`=0.
- `period`=5, mask 8'hFF, zero-wait ack: ticks land while busy; `overrun_cnt` increments once per scan, and every snapshot is complete.
- Mask 8'b1000_0101: requests only on channels 0, 2, 7 in that order; slots 1, 3–6 read 0.
- `adc_ack` delayed 3 cycles on channel 2: `adc_ch` is held at 2 with `adc_req` high for 4 cycles, and the data is captured on the ack cycle only.
- Timeout enabled with `TIMEOUT`=4:
  - Channel 3 never acks: slot 3 = 0, `timeout_err`=1, and the scan continues to channel 4.
  - An `err_clr` pulse clears the flag.
  - `err_clr` on the timeout cycle leaves the flag 1.
- `rst` asserted mid-scan while `adc_req` is high: `adc_req`, `busy` and all outputs are 0 immediately. After release, the next snapshot has `ts_now`=1.
